// File: rtl/dbus_data_ram.sv
// Word-organised data memory responding on the dbus: byte-lane stores, right-justified
// loads after LATENCY cycles, and fault flagging for misaligned or out-of-range accesses.
module dbus_data_ram #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rstf,
  input  logic [31:0] dbus_cmd_addr,
  input  logic [31:0] dbus_cmd_data,
  input  logic        dbus_cmd_we,
  input  logic [3:0]  dbus_cmd_size,
  input  logic        dbus_cmd_valid,
  output logic        dbus_cmd_ready,
  output logic [31:0] dbus_rsp_data,
  output logic        dbus_rsp_valid,
  output logic        dbus_rsp_err
);

  localparam int          IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] SPAN  = 33'(DEPTH * 4);

  if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
    $error("dbus_data_ram: LATENCY must be in 1..8");
  end
  if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
    $error("dbus_data_ram: BASE_ADDR must be 4-byte aligned");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_reg;
  logic [2:0]  cnt_reg;
  logic        ready_reg;
  logic [31:0] hold_data_reg;
  logic        hold_err_reg;
  logic [31:0] rsp_data_reg;
  logic        rsp_valid_reg;
  logic        rsp_err_reg;

  logic [31:0] mem [DEPTH];

  logic [32:0]      off;
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic [4:0]       shamt;
  logic             is_byte;
  logic             is_half;
  logic [3:0]       size_mask;
  logic [3:0]       byte_en;
  logic [31:0]      wdata;
  logic [31:0]      rd_word;
  logic [31:0]      rd_mask;
  logic [31:0]      merged;
  logic [31:0]      load_data;
  logic             out_of_range;
  logic             misaligned;
  logic             fault;
  logic             accept;
  logic             store_ok;
  logic             load_acc;

  // 33-bit offset so addresses below BASE_ADDR wrap to a huge value and fail the range test
  assign off          = {1'b0, dbus_cmd_addr} - {1'b0, BASE_ADDR};
  assign idx          = off[IDX_W+1:2];
  assign lane         = dbus_cmd_addr[1:0];
  assign shamt        = {lane, 3'b000};
  assign is_byte      = (dbus_cmd_size == 4'b0001);
  assign is_half      = (dbus_cmd_size == 4'b0011);
  assign size_mask    = is_byte ? 4'b0001 : (is_half ? 4'b0011 : 4'b1111);
  assign byte_en      = size_mask << lane;
  assign wdata        = dbus_cmd_data << shamt;
  assign out_of_range = (off >= SPAN);
  assign misaligned   = (is_half & lane[0]) | (~is_byte & ~is_half & (lane != 2'b00));
  assign fault        = out_of_range | misaligned;

  assign accept   = dbus_cmd_valid & ready_reg;
  assign store_ok = accept & dbus_cmd_we & ~fault;
  assign load_acc = accept & ~dbus_cmd_we;

  assign rd_word   = mem[idx];
  assign rd_mask   = is_byte ? 32'h0000_00FF : (is_half ? 32'h0000_FFFF : 32'hFFFF_FFFF);
  assign load_data = fault ? 32'h0 : ((rd_word >> shamt) & rd_mask);

  // Lane merge: enabled bytes take store data, the rest keep the current word
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign merged[8*gi +: 8] = byte_en[gi] ? wdata[8*gi +: 8] : rd_word[8*gi +: 8];
  end

  always_ff @(posedge clk) begin
    if (store_ok) begin
      mem[idx] <= merged;
    end
  end

  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= 3'd0;
      ready_reg     <= 1'b0;
      hold_data_reg <= 32'h0;
      hold_err_reg  <= 1'b0;
      rsp_data_reg  <= 32'h0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
    end else begin
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      case (state_reg)
        S_IDLE, S_RESP: begin
          if (load_acc) begin
            hold_data_reg <= load_data;
            hold_err_reg  <= fault;
            if (LATENCY == 1) begin
              state_reg     <= S_RESP;
              ready_reg     <= 1'b1;
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= fault;
              rsp_data_reg  <= load_data;
            end else begin
              state_reg <= S_WAIT;
              cnt_reg   <= 3'(LATENCY - 2);
              ready_reg <= 1'b0;
            end
          end else begin
            state_reg <= S_IDLE;
            ready_reg <= 1'b1;
            // A faulted store reports only through err, one cycle after accept
            if (accept && fault) begin
              rsp_err_reg <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (cnt_reg == 3'd0) begin
            state_reg     <= S_RESP;
            ready_reg     <= 1'b1;
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= hold_err_reg;
            rsp_data_reg  <= hold_data_reg;
          end else begin
            cnt_reg <= cnt_reg - 3'd1;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign dbus_cmd_ready = ready_reg;
  assign dbus_rsp_data  = rsp_data_reg;
  assign dbus_rsp_valid = rsp_valid_reg;
  assign dbus_rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_dbus_data_ram.sv
// Randomized bench for dbus_data_ram: three instances (LATENCY 1/3/4, one with offset base)
// checked cycle by cycle against a byte-addressed reference model.
module tb_dbus_data_ram;

  logic        clk;
  logic        rstf    [3];
  logic [31:0] c_addr  [3];
  logic [31:0] c_data  [3];
  logic        c_we    [3];
  logic [3:0]  c_size  [3];
  logic        c_valid [3];
  logic        r_ready [3];
  logic [31:0] r_data  [3];
  logic        r_valid [3];
  logic        r_err   [3];

  dbus_data_ram #(.DEPTH(1024), .BASE_ADDR(32'h0000_0000), .LATENCY(1)) u0 (
    .clk(clk), .rstf(rstf[0]), .dbus_cmd_addr(c_addr[0]), .dbus_cmd_data(c_data[0]),
    .dbus_cmd_we(c_we[0]), .dbus_cmd_size(c_size[0]), .dbus_cmd_valid(c_valid[0]),
    .dbus_cmd_ready(r_ready[0]), .dbus_rsp_data(r_data[0]), .dbus_rsp_valid(r_valid[0]),
    .dbus_rsp_err(r_err[0]));

  dbus_data_ram #(.DEPTH(16), .BASE_ADDR(32'h0000_1000), .LATENCY(3)) u1 (
    .clk(clk), .rstf(rstf[1]), .dbus_cmd_addr(c_addr[1]), .dbus_cmd_data(c_data[1]),
    .dbus_cmd_we(c_we[1]), .dbus_cmd_size(c_size[1]), .dbus_cmd_valid(c_valid[1]),
    .dbus_cmd_ready(r_ready[1]), .dbus_rsp_data(r_data[1]), .dbus_rsp_valid(r_valid[1]),
    .dbus_rsp_err(r_err[1]));

  dbus_data_ram #(.DEPTH(64), .BASE_ADDR(32'h0000_0000), .LATENCY(4)) u2 (
    .clk(clk), .rstf(rstf[2]), .dbus_cmd_addr(c_addr[2]), .dbus_cmd_data(c_data[2]),
    .dbus_cmd_we(c_we[2]), .dbus_cmd_size(c_size[2]), .dbus_cmd_valid(c_valid[2]),
    .dbus_cmd_ready(r_ready[2]), .dbus_rsp_data(r_data[2]), .dbus_rsp_valid(r_valid[2]),
    .dbus_rsp_err(r_err[2]));

  int          lat_m  [3] = '{1, 3, 4};
  int          dep_m  [3] = '{1024, 16, 64};
  logic [31:0] base_m [3] = '{32'h0, 32'h1000, 32'h0};
  int          win_m  [3] = '{64, 64, 256};

  typedef struct {
    int          d;
    int          due;
    bit          valid;
    bit          err;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  mb [longint];
  logic [31:0] last_data [3];
  int          lo [3];
  int          hi [3];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%08h exp=%08h", tag, cyc, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [3:0] s);
    if (s == 4'b0001) return 1;
    if (s == 4'b0011) return 2;
    return 4;
  endfunction

  // Reference: memory as individual bytes; a load concatenates the addressed bytes
  task automatic mdl_accept(input int d, input bit we, input logic [31:0] addr,
                            input logic [3:0] size, input logic [31:0] data);
    int          n;
    longint      off;
    longint      k;
    bit          fault;
    logic [31:0] res;
    exp_t        e;
    n     = nbytes(size);
    off   = longint'(addr) - longint'(base_m[d]);
    fault = (off < 0) || (off >= longint'(dep_m[d]) * 4) ||
            (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
    res   = 32'h0;
    if (we) begin
      if (fault) begin
        e.d = d; e.due = cyc + 1; e.valid = 1'b0; e.err = 1'b1; e.data = 32'h0;
        q.push_back(e);
      end else begin
        for (int i = 0; i < n; i++) mb[longint'(d) * 65536 + off + i] = data[8*i +: 8];
      end
    end else begin
      if (!fault) begin
        for (int i = 0; i < n; i++) begin
          k = longint'(d) * 65536 + off + i;
          res[8*i +: 8] = mb.exists(k) ? mb[k] : 8'h00;
        end
      end
      e.d = d; e.due = cyc + lat_m[d]; e.valid = 1'b1; e.err = fault; e.data = res;
      q.push_back(e);
      if (lat_m[d] > 1) begin
        lo[d] = cyc + 1;
        hi[d] = cyc + lat_m[d] - 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int d, input bit we, input logic [31:0] addr,
                       input logic [3:0] size, input logic [31:0] data);
    int tries;
    tries      = 0;
    c_valid[d] = 1'b1;
    c_we[d]    = we;
    c_addr[d]  = addr;
    c_size[d]  = size;
    c_data[d]  = data;
    while (!r_ready[d] && tries < 20) begin
      tick();
      tries++;
    end
    if (!r_ready[d]) begin
      chk($sformatf("u%0d_ready_timeout", d), 32'(r_ready[d]), 32'd1);
      c_valid[d] = 1'b0;
      return;
    end
    mdl_accept(d, we, addr, size, data);
    tick();
    c_valid[d] = 1'b0;
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rstf[d]) begin
        chk($sformatf("u%0d_rst_ready", d), 32'(r_ready[d]), 32'd0);
        chk($sformatf("u%0d_rst_valid", d), 32'(r_valid[d]), 32'd0);
        chk($sformatf("u%0d_rst_err", d), 32'(r_err[d]), 32'd0);
        chk($sformatf("u%0d_rst_data", d), r_data[d], 32'h0);
        last_data[d] = 32'h0;
      end else begin
        chk($sformatf("u%0d_ready", d), 32'(r_ready[d]),
            32'(!(cyc >= lo[d] && cyc <= hi[d])));
        if (q.size() > 0 && q[0].d == d && q[0].due == cyc) begin
          chk($sformatf("u%0d_rsp_valid", d), 32'(r_valid[d]), 32'(q[0].valid));
          chk($sformatf("u%0d_rsp_err", d), 32'(r_err[d]), 32'(q[0].err));
          if (q[0].valid) begin
            chk($sformatf("u%0d_rsp_data", d), r_data[d], q[0].data);
            last_data[d] = q[0].data;
          end else begin
            chk($sformatf("u%0d_hold_data", d), r_data[d], last_data[d]);
          end
          void'(q.pop_front());
        end else begin
          chk($sformatf("u%0d_no_rsp", d), {30'h0, r_valid[d], r_err[d]}, 32'h0);
          chk($sformatf("u%0d_hold_data", d), r_data[d], last_data[d]);
        end
      end
    end
  end

  function automatic logic [3:0] rand_size();
    int r;
    r = $urandom_range(0, 9);
    if (r < 3) return 4'b0001;
    if (r < 6) return 4'b0011;
    if (r < 9) return 4'b1111;
    return 4'($urandom_range(0, 15));
  endfunction

  function automatic logic [31:0] rand_addr(input int d);
    int r;
    r = $urandom_range(0, 9);
    if (r < 8) return base_m[d] + 32'($urandom_range(0, win_m[d] - 1));
    if (r == 8) return base_m[d] + 32'(dep_m[d] * 4) + 32'($urandom_range(0, 15));
    return base_m[d] - 32'($urandom_range(1, 8));
  endfunction

  task automatic run_random(input int d, input int nops);
    for (int i = 0; i < win_m[d] / 4; i++) issue(d, 1'b1, base_m[d] + 32'(4 * i), 4'b1111, $urandom);
    for (int i = 0; i < nops; i++) begin
      issue(d, 1'($urandom_range(0, 1)), rand_addr(d), rand_size(), $urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (q.size() > 0 && w < 50) begin
      tick();
      w++;
    end
    chk("drain_pending", 32'(q.size()), 32'd0);
    repeat (2) tick();
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rstf[d] = 1'b0; c_valid[d] = 1'b0; c_we[d] = 1'b0;
      c_addr[d] = 32'h0; c_data[d] = 32'h0; c_size[d] = 4'b1111;
      lo[d] = 1; hi[d] = 0; last_data[d] = 32'h0;
    end
    repeat (3) tick();
    for (int d = 0; d < 3; d++) begin
      rstf[d] = 1'b1;
      lo[d] = cyc; hi[d] = cyc;
    end
    tick();

    // LATENCY=1 lanes, read-after-write and misalignment
    issue(0, 1'b1, 32'h10, 4'b1111, 32'hDEAD_BEEF);
    issue(0, 1'b0, 32'h10, 4'b1111, 32'h0);
    issue(0, 1'b1, 32'h13, 4'b0001, 32'h0000_00AA);
    issue(0, 1'b0, 32'h10, 4'b1111, 32'h0);
    issue(0, 1'b0, 32'h12, 4'b0011, 32'h0);
    issue(0, 1'b0, 32'h11, 4'b0001, 32'h0);
    issue(0, 1'b1, 32'h11, 4'b0011, 32'h0000_1234);
    issue(0, 1'b0, 32'h10, 4'b1111, 32'h0);
    issue(0, 1'b0, 32'h12, 4'b1111, 32'h0);
    drain();
    run_random(0, 300);
    drain();

    // Offset base and range edges, then LATENCY=3 with a store right behind a load
    for (int i = 0; i < 16; i++) issue(1, 1'b1, 32'h1000 + 32'(4 * i), 4'b1111, $urandom);
    issue(1, 1'b0, 32'h1040, 4'b1111, 32'h0);
    issue(1, 1'b0, 32'h0FFC, 4'b1111, 32'h0);
    issue(1, 1'b0, 32'h103C, 4'b1111, 32'h0);
    issue(1, 1'b0, 32'h1020, 4'b1111, 32'h0);
    issue(1, 1'b1, 32'h1020, 4'b1111, 32'h1357_9BDF);
    issue(1, 1'b0, 32'h1020, 4'b1111, 32'h0);
    drain();
    run_random(1, 200);
    drain();

    // Reset one cycle after a LATENCY=4 load: response dropped, memory retained
    issue(2, 1'b1, 32'h20, 4'b1111, 32'hCAFE_F00D);
    issue(2, 1'b0, 32'h20, 4'b1111, 32'h0);
    drain();
    issue(2, 1'b0, 32'h20, 4'b1111, 32'h0);
    rstf[2] = 1'b0;
    for (int i = q.size() - 1; i >= 0; i--) if (q[i].d == 2) q.delete(i);
    lo[2] = 1; hi[2] = 0;
    repeat (2) tick();
    rstf[2] = 1'b1;
    lo[2] = cyc; hi[2] = cyc;
    repeat (10) tick();
    issue(2, 1'b0, 32'h20, 4'b1111, 32'h0);
    drain();
    run_random(2, 150);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/dbus_data_ram.md
Name: dbus_data_ram

Overview:
Word-organised data memory that sits on the dbus as the responder to the memory-access stage's initiator. It accepts one command per cycle on the cmd valid/ready handshake. Stores commit with byte-lane masking. Loads return right-justified data on dbus_rsp_* after a configurable latency. Misaligned or out-of-range accesses are flagged and cause no memory side effects.

Parameters:
DEPTH, 1024, memory size in 32-bit words; index width is $clog2(DEPTH).
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.
LATENCY, 1, cycles from load accept to rsp_valid; legal range 1..8, anything else is an elaboration error.

Ports:
clk  input  1  clock, all state on rising edge
rstf  input  1  asynchronous active-low reset
dbus_cmd_addr  input  32  byte address
dbus_cmd_data  input  32  store data, right-justified (byte in [7:0], half in [15:0])
dbus_cmd_we  input  1  1=store, 0=load
dbus_cmd_size  input  4  4'b0001 byte, 4'b0011 half, 4'b1111 word; other codes are treated as word
dbus_cmd_valid  input  1  command present
dbus_cmd_ready  output  1  responder can accept this cycle
dbus_rsp_data  output  32  load data, right-justified, zero-extended
dbus_rsp_valid  output  1  single-cycle load-response pulse
dbus_rsp_err  output  1  pulse with the response or accept, flagging a faulted access

Behaviour:
- Accept: accept = dbus_cmd_valid & dbus_cmd_ready. Every accept cycle is a new command; the responder does not merge commands while valid is held.
- Address decode:
  - off = addr - BASE_ADDR; idx = off[..:2]; lane = addr[1:0].
  - Out of range when off >= DEPTH*4, computed in 33-bit arithmetic so that addr < BASE_ADDR also faults.
- Misalignment:
  - half with lane[0]=1 faults;
  - word with lane!=0 faults;
  - bytes never fault on alignment.
- Stores:
  - Byte-enable = size shifted left by lane; write data = cmd_data shifted left by 8*lane.
  - Committed in the accept cycle; no rsp_valid is generated.
  - A faulted store writes nothing and pulses dbus_rsp_err in the cycle after accept.
- Loads:
  - Word read at accept.
  - Result = word >> 8*lane, masked to 8/16/32 bits per size. Sign extension is not done here.
  - A faulted load returns rsp_data=0 with rsp_err=1.
- FSM states:
  - IDLE: ready=1. Load accept goes to RESP if LATENCY==1, else to WAIT with cnt=LATENCY-2. A store accept stays in IDLE.
  - WAIT: ready=0. Decrement cnt; go to RESP when cnt==0.
  - RESP: rsp_valid=1 for exactly this cycle; ready=1. A load accepted here re-enters WAIT or RESP, giving back-to-back throughput of one load per cycle at LATENCY=1. A store accepted here commits and the FSM returns to IDLE.
- Response data is captured at accept into a holding register, so later stores cannot alter a response already in flight.
- Read-after-write: a store accepted at cycle T is visible to a load accepted at T+1.
- dbus_rsp_data holds its last value while rsp_valid=0. It is 0 after reset.
- Reset (asserted at any time, including mid-WAIT/RESP):
  - FSM to IDLE; ready=0 while rstf=0, 1 from the first clock after release;
  - rsp_valid=0, rsp_err=0, rsp_data=0;
  - an in-flight load is dropped with no response;
  - memory contents are not reset.

Test Plan:
- LATENCY=1: store word 0xDEADBEEF @0x10, then load word @0x10 the next cycle -> rsp_valid exactly one cycle after load accept, rsp_data=0xDEADBEEF, err=0, ready never deasserted.
- Byte/half lanes: store byte 0xAA @0x13, then load word @0x10 -> 0xAAADBEEF. Load half @0x12 -> 0x0000AAAD. Load byte @0x11 -> 0x000000BE.
- Misaligned: store half 0x1234 @0x11 -> err pulse, no rsp_valid, word @0x10 unchanged. Load word @0x12 -> rsp_valid with rsp_data=0, err=1.
- Out of range with BASE_ADDR=0x1000, DEPTH=16: load @0x1040 and load @0x0FFC -> both err=1, data=0. Load @0x103C -> normal, err=0.
- LATENCY=3: load accepted at T -> ready=0 at T+1 and T+2, rsp_valid at T+3 with ready=1. A store to the same address at T+3 does not change the T+3 rsp_data.
- Reset mid-op at LATENCY=4: rstf low one cycle after a load accept -> no rsp_valid ever issued for that load. After release, ready=1 and the memory still holds the pre-reset contents.
